// File: rtl/reaction_timer_pkg.sv
// Shared definitions for the reaction timer and its downstream score/display logic.
// Holds the FSM state encoding, the random-byte scaling shift and the delay width.
// Import this package wherever status from the timer needs to be decoded.
package reaction_timer_pkg;

  // Round state; the encoding is visible to downstream status decoders.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_FIRE = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // rand_in is scaled by 4 so one LFSR byte spans a ~1 s spread of delays.
  localparam int RAND_SHIFT = 2;

  // Delay register width: holds MIN_DELAY + (255 << RAND_SHIFT) = 1276 at defaults.
  localparam int DLY_W = 11;

endpackage

// File: rtl/reaction_timer_tick_prescaler.sv
// Tick prescaler: divides clk down to one-cycle tick pulses every DIV cycles.
// tick is decoded from the counter register, so it is high in the cycle pre == DIV-1.
// clr holds the counter at 0; it is used to restart the tick phase on every state entry.
module tick_prescaler #(
  parameter int DIV = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick
);

  localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PRE_W-1:0] LAST = PRE_W'(DIV - 1);

  logic [PRE_W-1:0] pre;

  // Free-running modulo-DIV counter, restarted by reset or clr.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      pre <= '0;
    end else if (pre == LAST) begin
      pre <= '0;
    end else begin
      pre <= pre + PRE_W'(1);
    end
  end

  assign tick = (pre == LAST);

endmodule

// File: rtl/reaction_timer.sv
// Reaction timer: random wait after start, then fire, then time the player's response.
// Start accepted at cycle n -> busy at n+1, fire at n+1+D*TICK_DIV, done 1 cycle after the end event.
// No backpressure: start is only honoured in IDLE/DONE, done holds its results until the next start.
module reaction_timer
  import reaction_timer_pkg::*;
#(
  parameter int TICK_DIV  = 50000,
  parameter int MIN_DELAY = 256,
  parameter int TIMEOUT   = 2000,
  parameter int RT_W      = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [7:0]      rand_in,
  input  logic            start,
  input  logic            resp,
  output logic            fire,
  output logic            busy,
  output logic            done,
  output logic            early,
  output logic            timeout,
  output logic [RT_W-1:0] result
);

  localparam logic [RT_W-1:0] RT_LAST   = RT_W'(TIMEOUT - 1);
  localparam logic [RT_W-1:0] RT_TMO    = RT_W'(TIMEOUT);
  localparam logic [DLY_W-1:0] DLY_MIN  = DLY_W'(MIN_DELAY);

  state_t            state;
  state_t            state_next;
  logic              resp_q;
  logic              resp_rise;
  logic              tick;
  logic              pre_clr;
  logic [DLY_W-1:0]  dly;
  logic [DLY_W-1:0]  dly_load;
  logic [RT_W-1:0]   rt;

  // A button already held when the round starts never produces a rise.
  assign resp_rise = resp & ~resp_q;
  assign dly_load  = DLY_MIN + (DLY_W'(rand_in) << RAND_SHIFT);

  // Prescaler only runs in WAIT/FIRE and restarts its phase on every state entry.
  assign pre_clr = (state_next != state) || (state == ST_IDLE) || (state == ST_DONE);

  tick_prescaler #(
    .DIV (TICK_DIV)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .clr   (pre_clr),
    .tick  (tick)
  );

  // Delayed copy of resp for rising-edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      resp_q <= 1'b0;
    end else begin
      resp_q <= resp;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; a response always takes priority over a coincident tick.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) state_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (resp_rise)                      state_next = ST_DONE;
        else if (tick && dly == DLY_W'(1))  state_next = ST_FIRE;
      end
      ST_FIRE: begin
        if (resp_rise)                      state_next = ST_DONE;
        else if (tick && rt == RT_LAST)     state_next = ST_DONE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Status outputs decoded straight from the state register.
  always_comb begin
    fire = (state == ST_FIRE);
    busy = (state == ST_WAIT) || (state == ST_FIRE);
    done = (state == ST_DONE);
  end

  // Delay/response counters and the result flags latched at the end of a round.
  always_ff @(posedge clk) begin
    if (reset) begin
      dly     <= '0;
      rt      <= '0;
      early   <= 1'b0;
      timeout <= 1'b0;
      result  <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            dly     <= dly_load;
            rt      <= '0;
            early   <= 1'b0;
            timeout <= 1'b0;
            result  <= '0;
          end
        end
        ST_WAIT: begin
          if (resp_rise) begin
            early  <= 1'b1;
            result <= '0;
          end else if (tick) begin
            dly <= dly - DLY_W'(1);
          end
        end
        ST_FIRE: begin
          if (resp_rise) begin
            result <= rt;
          end else if (tick) begin
            rt <= rt + RT_W'(1);
            if (rt == RT_LAST) begin
              timeout <= 1'b1;
              result  <= RT_TMO;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
